lb_uart_tx_sequencer: RTL and testbench
=======================================

# lb_uart_tx_sequencer

UART transmit sequencer driven by the 16x baud tick stream from the shared 16x baud tick counter. It accepts a byte from the PicoBlaze I/O port logic and frames it as start, data (LSB first), optional parity and stop. It counts 16 oversample ticks per bit and resynchronises the tick counter at the start of each frame. It sits between the processor's output-port decode and the TX pin.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..8.
- `STOP_TICKS`, 16: tick_16x pulses in the stop period; legal values 16 (1 stop bit) and 32 (2 stop bits).
- `clk` in 1: system clock; the only clock.
- `reset` in 1: reset; synchronous, active-high.
- `tick_16x` in 1: one-cycle pulse at 16x the baud rate, from the tick counter's `done`.
- `tx_start` in 1: frame request; sampled only in IDLE.
- `tx_data` in DATA_BITS: byte to send; latched on acceptance.
- `baud_clr` out 1: one-cycle pulse that clears and restarts the tick counter.
- `tx_busy` out 1: high from acceptance until the end of the stop period.
- `tx_done` out 1: one-cycle pulse when a frame completes.
- `tx` out 1: serial line; idles high.

## Operation
- States are IDLE, START, DATA, PARITY (present only with `LB_UART_TX_PARITY_EN`) and STOP.
- Internal counters:
  - `s_cnt` (4 bits) counts tick_16x pulses within a bit.
  - `n_cnt` (3 bits) holds the data bit index.
  - `sh` is a DATA_BITS-wide shift register.
- In IDLE:
  - `tx`=1, `tx_busy`=0, and tick_16x is ignored.
  - When `tx_start`=1, latch `tx_data` into `sh`, clear `s_cnt` and `n_cnt`, and go to START.
- Bit boundary: a cycle with tick_16x=1 and s_cnt=15. On any other tick_16x, s_cnt increments.
- START: `tx`=0. At the bit boundary, go to DATA.
- DATA: `tx`=sh[0]. At each bit boundary, shift `sh` right and increment n_cnt. When n_cnt=DATA_BITS-1, go to PARITY, or to STOP if parity is compiled out.
- PARITY: `tx` = even parity (XOR) of the latched data. At the bit boundary, go to STOP.
- STOP: `tx`=1. It lasts STOP_TICKS ticks, counted by s_cnt plus one extra wrap when STOP_TICKS=32. On the last tick: go to IDLE, pulse `tx_done`, and drop `tx_busy`.
- `tx_start` while busy is ignored; there is no queuing and no error flag.
- `tx_data` changes after acceptance have no effect on the frame in flight.
- If `tx_start` and tick_16x are both high in IDLE, the tick is not counted.
- `reset` mid-frame: on the next edge the block returns to IDLE with `tx`=1, `tx_busy`=0, `tx_done`=0 and `baud_clr`=0. The frame is abandoned with no glitch to 0.

## Timing
- All outputs are registered.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `baud_clr`=0.
- Acceptance edge k (IDLE, tx_start=1): in cycle k+1, `tx`=0, `tx_busy`=1 and `baud_clr`=1. `baud_clr` lasts exactly one cycle.
- The first tick counted is the first tick_16x after the tick counter restarts.
- Each bit lasts exactly 16 tick_16x pulses. `tx` changes one cycle after the 16th tick's edge.
- Frame length in ticks: 16 × (1 + DATA_BITS + parity) + STOP_TICKS.
- `tx_done` is high for the single cycle in which `tx_busy` first reads 0.
- A new `tx_start` is accepted in that same cycle, giving back-to-back frames with no idle gap.

## Configuration
- `LB_UART_TX_PARITY_EN` defined: the PARITY state exists and one even-parity bit is inserted between the data and stop bits.
- Undefined: no PARITY state, no parity logic, and DATA goes directly to STOP.

## Structure
- Package `lb_uart_pkg` holds:
  - the state encoding type;
  - the `TICKS_PER_BIT`=16 constant;
  - the default DATA_BITS and STOP_TICKS constants, shared with the future RX block.
- One natural sub-module is `lb_uart_bit_timer`: the s_cnt counter with a bit-boundary output, reusable by RX.
- The tick counter itself is instantiated at the top level, not inside this block.

## Test plan
- Reset held with tick_16x toggling: `tx`=1, `tx_busy`=0 and `tx_done`=0 throughout. No `baud_clr`.
- Tick every 4 clocks (prescale 3), 8N1, send 0x55:
  - `baud_clr` pulses once after acceptance.
  - `tx` shows 0,1,0,1,0,1,0,1,0,1, each bit held for 64 clocks.
  - `tx_done` occurs 640 clocks (±4) after acceptance.
- Parity enabled, send 0x07: data bits 1,1,1,0,0,0,0,0, then parity=1, then stop. Total frame is 176 ticks.
- `tx_start` pulsed mid-frame with `tx_data`=0xFF while sending 0x00: the frame still carries all-zero data and no second frame follows.
- `tx_start` held high continuously, sending 0xA5 then 0x3C: the second start bit begins the cycle after `tx_done` and there is no idle-high gap.
- `reset` asserted during DATA bit 3: `tx`=1 on the next cycle and `tx_busy`=0. The next `tx_start` produces a clean full frame.

Source files
------------

// File: rtl/lb_uart_pkg.sv
// Shared UART definitions: state encoding and the framing constants shared by TX and RX.
// The PARITY state exists only when LB_UART_TX_PARITY_EN is defined.
package lb_uart_pkg;

  localparam int TICKS_PER_BIT  = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_STOP_TICKS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef LB_UART_TX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } tx_state_e;

endpackage

// File: rtl/lb_uart_bit_timer.sv
// Oversample counter: counts TICKS_PER_BIT ticks per bit and flags the tick that ends a bit.
module lb_uart_bit_timer
  import lb_uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic tick_i,
  output logic bit_end_o
);

  localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

  logic [3:0] s_cnt_q;
  logic [3:0] s_cnt_d;

  always_comb begin
    s_cnt_d = s_cnt_q;
    if (clr_i) begin
      s_cnt_d = '0;
    end else if (tick_i) begin
      s_cnt_d = (s_cnt_q == LAST_TICK) ? 4'd0 : s_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_cnt_q <= '0;
    end else begin
      s_cnt_q <= s_cnt_d;
    end
  end

  assign bit_end_o = tick_i && (s_cnt_q == LAST_TICK);

endmodule

// File: rtl/lb_uart_tx_sequencer.sv
// UART transmit sequencer: start, DATA_BITS data bits LSB first, optional even parity
// (LB_UART_TX_PARITY_EN) and 1 or 2 stop bits, paced by an external 16x tick.
module lb_uart_tx_sequencer
  import lb_uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int STOP_TICKS = DEF_STOP_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 baud_clr,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       TWO_STOP = (STOP_TICKS == 2 * TICKS_PER_BIT);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0]           n_cnt_q, n_cnt_d;
  logic                 wrap_q, wrap_d;
`ifdef LB_UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic clr_q, clr_d;

  logic accept;
  logic tick_cnt;
  logic bit_end;

  assign accept = (state_q == ST_IDLE) && tx_start;
  // A tick seen while baud_clr is out belongs to the tick counter's old count.
  assign tick_cnt = tick_16x && (state_q != ST_IDLE) && !clr_q;

  lb_uart_bit_timer u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (accept),
    .tick_i   (tick_cnt),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      n_cnt_q <= '0;
      wrap_q  <= 1'b0;
`ifdef LB_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      n_cnt_q <= n_cnt_d;
      wrap_q  <= wrap_d;
`ifdef LB_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    n_cnt_d = n_cnt_q;
    wrap_d  = wrap_q;
`ifdef LB_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          sh_d    = tx_data;
          n_cnt_d = '0;
          wrap_d  = 1'b0;
`ifdef LB_UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          sh_d    = sh_q >> 1;
          n_cnt_d = n_cnt_q + 3'd1;
          if (n_cnt_q == LAST_BIT) begin
`ifdef LB_UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef LB_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Two stop bits are one extra pass of the 16-tick counter.
        if (bit_end) begin
          if (TWO_STOP && !wrap_q) begin
            wrap_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    clr_d  = accept;
    tx_d   = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = sh_d[0];
`ifdef LB_UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign baud_clr = clr_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_lb_uart_tx_sequencer.sv
// Self-checking bench for lb_uart_tx_sequencer: tick-count frame model checked every cycle,
// plus directed frames with hand-computed bit patterns and lengths.
module tb_lb_uart_tx_sequencer;

  localparam int DB = 8;
  localparam int ST = 16;
`ifdef LB_UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DB + PB + 1;
  localparam int FT = 16 * (1 + DB + PB) + ST;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_16x = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       baud_clr, tx_busy, tx_done, tx;

  lb_uart_tx_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .tick_16x(tick_16x),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .baud_clr(baud_clr),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_count = 0;
  int done_count = 0;
  int last_clr = 0;
  int last_done = 0;
  bit chk_en = 1'b0;
  bit tx_log [0:65535];

  int presc = 3;
  int tcnt = 0;
  bit rnd_ticks = 1'b1;

  task automatic chk(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d actual %b required %b", nm, cyc, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual %0d required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Reference model: a frame is a list of bits, each lasting 16 counted ticks.
  logic        exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0, exp_clr = 1'b0;
  bit          m_active = 1'b0;
  int          m_ticks = 0;
  logic [15:0] m_bits = '1;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_clr = 1'b0;
    end else if (!m_active) begin
      exp_done = 1'b0;
      if (tx_start) begin
        m_bits = '1;
        m_bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) m_bits[1 + i] = tx_data[i];
        if (PB == 1) m_bits[1 + DB] = ^tx_data;
        m_active = 1'b1;
        m_ticks = 0;
        exp_clr = 1'b1; exp_busy = 1'b1; exp_tx = 1'b0;
      end else begin
        exp_clr = 1'b0; exp_busy = 1'b0; exp_tx = 1'b1;
      end
    end else begin
      if (tick_16x && !exp_clr) m_ticks++;
      exp_clr = 1'b0;
      if (m_ticks == FT) begin
        m_active = 1'b0;
        exp_done = 1'b1; exp_busy = 1'b0; exp_tx = 1'b1;
      end else begin
        exp_tx = m_bits[m_ticks / 16];
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (cyc < 65536) tx_log[cyc] = tx;
    if (baud_clr === 1'b1) begin clr_count++; last_clr = cyc; end
    if (tx_done === 1'b1) begin done_count++; last_done = cyc; end
    if (chk_en) begin
      chk("tx", tx, exp_tx);
      chk("tx_busy", tx_busy, exp_busy);
      chk("tx_done", tx_done, exp_done);
      chk("baud_clr", baud_clr, exp_clr);
    end
  end

  // Mid-bit samples of a frame whose baud_clr was in cycle clr_c, tick period per clocks.
  function automatic int grab(input int clr_c, input int per);
    int v = 0;
    for (int b = 0; b < NB; b++) begin
      if (tx_log[clr_c + 1 + 16 * per * b + 8 * per]) v = v | (1 << b);
    end
    return v;
  endfunction

  task automatic cycle();
    @(negedge clk);
    #1;
    if (rnd_ticks) tick_16x = ($urandom_range(0, 2) == 0);
    else tick_16x = (tcnt == presc);
    if (baud_clr || tcnt >= presc) tcnt = 0;
    else tcnt++;
  endtask

  task automatic send(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data = d;
    cycle();
    tx_start = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_done(input int maxc, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      cycle();
      seen = (tx_done === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s no tx_done within %0d cycles", nm, maxc);
    end
  endtask

`ifdef LB_UART_TX_PARITY_EN
  localparam int BITS_55 = 'h4AA, BITS_07 = 'h60E, BITS_00 = 'h400;
  localparam int BITS_A5 = 'h54A, BITS_3C = 'h478, BITS_96 = 'h52C;
  localparam int DONE_55 = 706,   LEN_P1 = 177;
`else
  localparam int BITS_55 = 'h2AA, BITS_07 = 'h20E, BITS_00 = 'h200;
  localparam int BITS_A5 = 'h34A, BITS_3C = 'h278, BITS_96 = 'h32C;
  localparam int DONE_55 = 642,   LEN_P1 = 161;
`endif

  initial begin
    int n0, c1, d1, c0;
    cycle();
    chk_en = 1'b1;

    // Reset held with ticks and requests toggling.
    repeat (24) begin
      tx_start = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      cycle();
    end
    chk_int("reset_no_baud_clr", clr_count, 0);
    reset = 1'b0; tx_start = 1'b0;
    rnd_ticks = 1'b0; presc = 3;
    repeat (3) cycle();

    // 0x55, tick every 4 clocks.
    n0 = clr_count;
    send(8'h55);
    wait_done(4000, "f55");
    chk_int("f55_clr_pulses", clr_count - n0, 1);
    chk_int("f55_bits", grab(last_clr, 4), BITS_55);
    chk_range("f55_done_after_accept", last_done - (last_clr - 1), DONE_55 - 4, DONE_55 + 4);

    // 0x07, tick every clock: bit pattern and total frame length.
    presc = 0;
    repeat (2) cycle();
    send(8'h07);
    wait_done(1000, "f07");
    chk_int("f07_bits", grab(last_clr, 1), BITS_07);
    chk_int("f07_len", last_done - last_clr, LEN_P1);

    // 0x00 with a mid-frame request carrying 0xFF.
    n0 = clr_count;
    send(8'h00);
    repeat (40) cycle();
    tx_start = 1'b1; tx_data = 8'hFF;
    cycle();
    tx_start = 1'b0;
    wait_done(1000, "f00");
    c0 = last_clr;
    repeat (40) cycle();
    chk_int("f00_bits", grab(c0, 1), BITS_00);
    chk_int("f00_single_frame", clr_count - n0, 1);

    // tx_start held high: 0xA5 then 0x3C back to back.
    tx_start = 1'b1; tx_data = 8'hA5;
    cycle();
    tx_data = 8'h3C;
    c1 = last_clr;
    wait_done(1000, "fA5");
    d1 = last_done;
    cycle();
    tx_start = 1'b0;
    chk_int("b2b_restart_cycle", last_clr, d1 + 1);
    chk("b2b_start_bit", tx, 1'b0);
    wait_done(1000, "f3C");
    chk_int("fA5_bits", grab(c1, 1), BITS_A5);
    chk_int("f3C_bits", grab(d1 + 1, 1), BITS_3C);

    // Reset during data bit 3, then a clean frame.
    repeat (3) cycle();
    send(8'hF0);
    repeat (16 * 4 + 8) cycle();
    reset = 1'b1;
    cycle();
    chk("rst_tx_high", tx, 1'b1);
    chk("rst_busy_low", tx_busy, 1'b0);
    reset = 1'b0;
    cycle();
    send(8'h96);
    wait_done(1000, "f96");
    chk_int("f96_bits", grab(last_clr, 1), BITS_96);
    chk_int("f96_len", last_done - last_clr, LEN_P1);

    // Random ticks, requests, data and occasional reset.
    rnd_ticks = 1'b1;
    n0 = done_count;
    for (int i = 0; i < 40000 && (done_count - n0) < 25; i++) begin
      tx_start = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      reset = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    reset = 1'b0; tx_start = 1'b0;
    repeat (4) cycle();
    chk_range("random_frames_done", done_count - n0, 25, 1000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
